// File: rtl/divs_p4y2_pkg.sv
// Shared widths, state encoding and wrapper bit map
// for the sign-magnitude restoring divider.
package divs_p4y2_pkg;

  localparam int P_WIDTH = 4;
  localparam int Y_WIDTH = 2;
  localparam int CNT_W   = $clog2(P_WIDTH);

  // Bit positions used by the Tiny Tapeout wrapper
  localparam int I_START_BITID = 0;
  localparam int I_PS_BITID    = 1;
  localparam int I_P_BITID     = 2;
  localparam int I_YS_BITID    = 6;
  localparam int I_Y_BITID     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divs_p4y2_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module divs_step
  import divs_p4y2_pkg::*;
(
  input  logic [Y_WIDTH:0]   rem,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               dbit,
  output logic [Y_WIDTH:0]   rem_n,
  output logic               qbit
);

  logic [Y_WIDTH:0] shifted;
  logic [Y_WIDTH:0] y_ext;

  always_comb begin
    shifted = {rem[Y_WIDTH-1:0], dbit};
    y_ext   = {1'b0, y};
    qbit    = (shifted >= y_ext);
    rem_n   = qbit ? (shifted - y_ext) : shifted;
  end

endmodule

// File: rtl/divs_p4y2.sv
// Sequential sign-magnitude divider, one quotient bit
// per clock, results held until the next start.
module divs_p4y2
  import divs_p4y2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic               ps,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               ys,
  output logic [P_WIDTH-1:0] q,
  output logic               qs,
  output logic [Y_WIDTH-1:0] r,
  output logic               rs,
  output logic               dbz,
  output logic               busy,
  output logic               rdy
);

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic               fin;
  logic [P_WIDTH-1:0] dvd;
  logic [P_WIDTH-1:0] quo;
  logic [Y_WIDTH:0]   rem;
  logic [Y_WIDTH:0]   rem_n;
  logic [Y_WIDTH-1:0] y_l;
  logic               ps_l;
  logic               ys_l;
  logic               qbit;
  logic               load;

  divs_step u_step (
    .rem   (rem),
    .y     (y_l),
    .dbit  (dvd[P_WIDTH-1]),
    .rem_n (rem_n),
    .qbit  (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN:     if (fin) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign rdy  = (state == DONE);

  // fin marks the extra cycle that publishes the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      fin  <= 1'b0;
      dvd  <= '0;
      quo  <= '0;
      rem  <= '0;
      y_l  <= '0;
      ps_l <= 1'b0;
      ys_l <= 1'b0;
      q    <= '0;
      qs   <= 1'b0;
      r    <= '0;
      rs   <= 1'b0;
      dbz  <= 1'b0;
    end else if (load) begin
      cnt  <= CNT_W'(P_WIDTH - 1);
      fin  <= (y == '0);
      dvd  <= p;
      quo  <= '0;
      rem  <= '0;
      y_l  <= y;
      ps_l <= ps;
      ys_l <= ys;
    end else if (state == RUN) begin
      if (!fin) begin
        dvd <= {dvd[P_WIDTH-2:0], 1'b0};
        quo <= {quo[P_WIDTH-2:0], qbit};
        rem <= rem_n;
        if (cnt == '0) fin <= 1'b1;
        else           cnt <= cnt - 1'b1;
      end else if (y_l == '0) begin
        q   <= '1;
        qs  <= ps_l ^ ys_l;
        r   <= '0;
        rs  <= 1'b0;
        dbz <= 1'b1;
      end else begin
        q   <= quo;
        qs  <= (ps_l ^ ys_l) & (|quo);
        r   <= rem[Y_WIDTH-1:0];
        rs  <= ps_l & (|rem);
        dbz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divs_p4y2.sv
// Randomised and directed bench for divs_p4y2 against
// a plain-arithmetic division model.
module tb_divs_p4y2;
  import divs_p4y2_pkg::*;

  localparam int RW = P_WIDTH + Y_WIDTH + 3;
  localparam int LAT = P_WIDTH + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [P_WIDTH-1:0] p;
  logic               ps;
  logic [Y_WIDTH-1:0] y;
  logic               ys;
  logic [P_WIDTH-1:0] q;
  logic               qs;
  logic [Y_WIDTH-1:0] r;
  logic               rs;
  logic               dbz;
  logic               busy;
  logic               rdy;

  int total  = 0;
  int passed = 0;

  divs_p4y2 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .p     (p),
    .ps    (ps),
    .y     (y),
    .ys    (ys),
    .q     (q),
    .qs    (qs),
    .r     (r),
    .rs    (rs),
    .dbz   (dbz),
    .busy  (busy),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  wire [RW-1:0] res = {q, qs, r, rs, dbz};

  function automatic logic [RW-1:0] model(
    input int pv, input bit psv, input int yv, input bit ysv);
    logic [P_WIDTH-1:0] qq;
    logic [Y_WIDTH-1:0] rr;
    bit qsv, rsv, z;
    if (yv == 0) begin
      qq  = '1;
      rr  = '0;
      z   = 1'b1;
      qsv = psv ^ ysv;
      rsv = 1'b0;
    end else begin
      qq  = P_WIDTH'(pv / yv);
      rr  = Y_WIDTH'(pv % yv);
      z   = 1'b0;
      qsv = (psv ^ ysv) && (pv / yv != 0);
      rsv = psv && (pv % yv != 0);
    end
    return {qq, qsv, rr, rsv, z};
  endfunction

  task automatic scramble();
    p  = P_WIDTH'($urandom);
    ps = 1'($urandom);
    y  = Y_WIDTH'($urandom);
    ys = 1'($urandom);
  endtask

  // Launch one division; lat = edges from start to rdy
  task automatic issue(input int pv, input bit psv,
    input int yv, input bit ysv, output int lat);
    p = P_WIDTH'(pv); ps = psv; y = Y_WIDTH'(yv); ys = ysv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    lat = 0;
    while (!rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    total++;
    if ({res, busy, rdy} !== '0)
      $display("FAIL reset_state got=%b want=0", {res, busy, rdy});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, rdy} !== 2'b00)
      $display("FAIL idle_flags got=%b want=00", {busy, rdy});
    else passed++;
  endtask

  task automatic test_directed();
    int cp[5]  = '{13, 13, 13, 2, 15};
    bit cps[5] = '{0, 1, 1, 1, 0};
    int cy[5]  = '{3, 3, 3, 3, 1};
    bit cys[5] = '{0, 0, 1, 0, 0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(cp[i], cps[i], cy[i], cys[i], lat);
      total++;
      if (lat !== LAT)
        $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT);
      else passed++;
      total++;
      if (res !== model(cp[i], cps[i], cy[i], cys[i]))
        $display("FAIL dir%0d_result got=%b want=%b", i, res,
          model(cp[i], cps[i], cy[i], cys[i]));
      else passed++;
    end
    total++;
    if (res !== 9'b1111_0_00_0_0)
      $display("FAIL fifteen_by_one got=%b want=111100000", res);
    else passed++;
  endtask

  task automatic test_dbz();
    int lat;
    issue(7, 0, 0, 0, lat);
    total++;
    if (lat !== 1)
      $display("FAIL dbz_latency got=%0d want=1", lat);
    else passed++;
    total++;
    if (res !== 9'b1111_0_00_0_1)
      $display("FAIL dbz_result got=%b want=111100001", res);
    else passed++;
    issue(7, 1, 0, 0, lat);
    total++;
    if (res !== model(7, 1, 0, 0) || lat !== 1)
      $display("FAIL dbz_neg got=%b/%0d want=%b/1", res, lat,
        model(7, 1, 0, 0));
    else passed++;
  endtask

  task automatic test_ignore_start();
    int lat;
    p = 4'd11; ps = 1'b1; y = 2'd2; ys = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || rdy !== 1'b0)
      $display("FAIL run_flags got=%b%b want=10", busy, rdy);
    else passed++;
    lat = 0;
    @(negedge clk); lat++;
    p = 4'd3; ps = 1'b0; y = 2'd0; ys = 1'b1;
    start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== LAT)
      $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT);
    else passed++;
    total++;
    if (res !== model(11, 1, 2, 0))
      $display("FAIL ignore_result got=%b want=%b", res,
        model(11, 1, 2, 0));
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (rdy !== 1'b1 || res !== model(11, 1, 2, 0))
      $display("FAIL done_hold got=%b/%b want=1/%b", rdy, res,
        model(11, 1, 2, 0));
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    p = 4'd9; ps = 1'b1; y = 2'd2; ys = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({res, busy, rdy} !== '0)
      $display("FAIL reset_mid got=%b want=0", {res, busy, rdy});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(14, 0, 3, 1, lat);
    total++;
    if (lat !== LAT || res !== model(14, 0, 3, 1))
      $display("FAIL after_reset got=%b/%0d want=%b/%0d", res, lat,
        model(14, 0, 3, 1), LAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [RW-1:0] prev;
    issue(10, 1, 3, 0, lat);
    prev = model(10, 1, 3, 0);
    p = 4'd5; ps = 1'b0; y = 2'd2; ys = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (rdy !== 1'b0 || res !== prev)
      $display("FAIL b2b_hold got=%b/%b want=0/%b", rdy, res, prev);
    else passed++;
    lat = 0;
    while (!rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== LAT)
      $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT);
    else passed++;
    total++;
    if (res !== model(5, 0, 2, 1))
      $display("FAIL b2b_result got=%b want=%b", res,
        model(5, 0, 2, 1));
    else passed++;
  endtask

  task automatic test_random();
    int pv, yv, lat, want_lat;
    bit psv, ysv;
    for (int i = 0; i < 40; i++) begin
      pv  = $urandom_range(0, (1 << P_WIDTH) - 1);
      yv  = $urandom_range(0, (1 << Y_WIDTH) - 1);
      psv = 1'($urandom);
      ysv = 1'($urandom);
      want_lat = (yv == 0) ? 1 : LAT;
      issue(pv, psv, yv, ysv, lat);
      total++;
      if (lat !== want_lat || res !== model(pv, psv, yv, ysv))
        $display("FAIL rand%0d p=%0d/%0d y=%0d/%0d got=%b/%0d want=%b/%0d",
          i, pv, psv, yv, ysv, res, lat,
          model(pv, psv, yv, ysv), want_lat);
      else passed++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    scramble();
    @(negedge clk);
    test_reset();
    test_directed();
    test_dbz();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
